// File: rtl/adder_chain_sequencer.sv
// Multi-word add sequencer: feeds one 5-bit slice per clock into a shared external adder, chaining carry.
// Optional subtract mode is enabled by defining ADDSEQ_SUB_EN (adds the sub_in port).
module adder_chain_sequencer #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [5*WORDS-1:0] a_in,
    input  logic [5*WORDS-1:0] b_in,
    input  logic               cin_in,
`ifdef ADDSEQ_SUB_EN
    input  logic               sub_in,
`endif
    output logic               busy,
    output logic               done,
    output logic [5*WORDS-1:0] sum_out,
    output logic               cout_out,
    output logic [4:0]         adder_a,
    output logic [4:0]         adder_b,
    output logic               adder_cin,
    input  logic [4:0]         adder_sum,
    input  logic               adder_cout
);

    localparam int OP_W  = 5 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [OP_W-1:0]  op_a_reg;
    logic [OP_W-1:0]  op_b_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [OP_W-1:0]  sum_reg;
    logic             cout_reg;

    logic [OP_W-1:0]  b_capture;
    logic             cin_capture;

    // Subtraction is A + ~B + 1: B is inverted once at capture so the run path stays add-only.
`ifdef ADDSEQ_SUB_EN
    assign b_capture   = sub_in ? ~b_in : b_in;
    assign cin_capture = sub_in ? 1'b1 : cin_in;
`else
    assign b_capture   = b_in;
    assign cin_capture = cin_in;
`endif

    logic [4:0] a_slice [WORDS];
    logic [4:0] b_slice [WORDS];

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_slice
            assign a_slice[gi] = op_a_reg[5*gi +: 5];
            assign b_slice[gi] = op_b_reg[5*gi +: 5];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_a_reg  <= a_in;
                        op_b_reg  <= b_capture;
                        carry_reg <= cin_capture;
                        idx_reg   <= '0;
                        cout_reg  <= 1'b0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_reg[5*idx_reg +: 5] <= adder_sum;
                    carry_reg               <= adder_cout;
                    if (idx_reg == LAST_IDX) begin
                        cout_reg  <= adder_cout;
                        idx_reg   <= '0;
                        state_reg <= ST_DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    logic running;
    assign running   = (state_reg == ST_RUN);
    assign busy      = running || (state_reg == ST_DONE);
    assign done      = (state_reg == ST_DONE);
    assign sum_out   = sum_reg;
    assign cout_out  = cout_reg;
    assign adder_a   = running ? a_slice[idx_reg] : 5'd0;
    assign adder_b   = running ? b_slice[idx_reg] : 5'd0;
    assign adder_cin = running ? carry_reg : 1'b0;

endmodule

// File: tb/tb_adder_chain_sequencer.sv
// Randomized self-checking bench for adder_chain_sequencer (WORDS=4); the shared 5-bit adder is modelled here.
module tb_adder_chain_sequencer;

    localparam int WORDS = 4;
    localparam int OW    = 5 * WORDS;
    localparam int TMO   = 30;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [OW-1:0] a_in;
    logic [OW-1:0] b_in;
    logic          cin_in;
    logic          sub_in;
    logic          busy;
    logic          done;
    logic [OW-1:0] sum_out;
    logic          cout_out;
    logic [4:0]    adder_a;
    logic [4:0]    adder_b;
    logic          adder_cin;
    logic [4:0]    adder_sum;
    logic          adder_cout;

    int checks = 0;
    int errors = 0;

    adder_chain_sequencer #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .cin_in     (cin_in),
`ifdef ADDSEQ_SUB_EN
        .sub_in     (sub_in),
`endif
        .busy       (busy),
        .done       (done),
        .sum_out    (sum_out),
        .cout_out   (cout_out),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout)
    );

    // Stand-in for the shared adderFiveBits instance.
    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {5'd0, adder_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OW:0] ref_op(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                           input logic cin, input logic sub);
        logic [OW:0] r;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + (OW+1)'(1);
        else     r = {1'b0, a} + {1'b0, b} + {{OW{1'b0}}, cin};
        return r;
    endfunction

    // Drives one operation; reports latency (edges after acceptance until done), busy cycles and result.
    task automatic do_op(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic cin,
                         input logic sub, output int lat, output int busy_cycles,
                         output logic [OW-1:0] s, output logic c, output logic done_after,
                         output logic [4:0] first_a);
        @(posedge clk); #1;
        a_in = a; b_in = b; cin_in = cin; sub_in = sub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        first_a = adder_a;
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < TMO) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy) busy_cycles++;
        s = sum_out;
        c = cout_out;
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
        #13;
        checks++;
        if ({busy, done, sum_out, cout_out, adder_a, adder_b, adder_cin} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b a=%h b=%h cin=%b, required all 0",
                     busy, done, sum_out, cout_out, adder_a, adder_b, adder_cin);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
        end
        $display("test_reset: done");
    endtask

    task automatic test_directed;
        logic [OW-1:0] av [3] = '{20'h00019, 20'hFFFFF, 20'h00000};
        logic [OW-1:0] bv [3] = '{20'h00007, 20'h00001, 20'h00000};
        logic          cv [3] = '{1'b0, 1'b0, 1'b1};
        logic [OW-1:0] sx [3] = '{20'h00020, 20'h00000, 20'h00001};
        logic          cx [3] = '{1'b0, 1'b1, 1'b0};
        int lat, bc;
        logic [OW-1:0] s;
        logic c, da;
        logic [4:0] fa;
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], bv[i], cv[i], 1'b0, lat, bc, s, c, da, fa);
            $display("directed %0d: A=%h B=%h cin=%b -> sum=%h cout=%b lat=%0d busy=%0d",
                     i, av[i], bv[i], cv[i], s, c, lat, bc);
            checks++;
            if (s !== sx[i] || c !== cx[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: sum=%h cout=%b, required sum=%h cout=%b",
                         i, s, c, sx[i], cx[i]);
            end
            checks++;
            if (lat !== WORDS) begin
                errors++;
                $display("FAIL directed_latency[%0d]: %0d edges, required %0d", i, lat, WORDS);
            end
            checks++;
            if (bc !== WORDS + 1) begin
                errors++;
                $display("FAIL directed_busy[%0d]: busy %0d cycles, required %0d", i, bc, WORDS + 1);
            end
            checks++;
            if (da !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL directed_done_pulse[%0d]: done=%b busy=%b after done cycle, required 0 0",
                         i, da, busy);
            end
        end
        checks++;
        if (adder_a !== 5'd0 || adder_b !== 5'd0 || adder_cin !== 1'b0) begin
            errors++;
            $display("FAIL idle_adder_drive: a=%h b=%h cin=%b, required 0", adder_a, adder_b, adder_cin);
        end
    endtask

    task automatic test_random;
        int lat, bc;
        logic [OW-1:0] a, b, s;
        logic cin, c, da;
        logic [4:0] fa;
        logic [OW:0] r;
        for (int i = 0; i < 25; i++) begin
            a = OW'($urandom);
            b = OW'($urandom);
            if (i % 5 == 0) a = OW'(~b);
            cin = 1'($urandom);
            r = ref_op(a, b, cin, 1'b0);
            do_op(a, b, cin, 1'b0, lat, bc, s, c, da, fa);
            $display("random %0d: A=%h B=%h cin=%b -> sum=%h cout=%b (ref %h %b)",
                     i, a, b, cin, s, c, r[OW-1:0], r[OW]);
            checks++;
            if (s !== r[OW-1:0] || c !== r[OW] || lat !== WORDS) begin
                errors++;
                $display("FAIL random_result[%0d]: sum=%h cout=%b lat=%0d, required sum=%h cout=%b lat=%0d",
                         i, s, c, lat, r[OW-1:0], r[OW], WORDS);
            end
            checks++;
            if (fa !== a[4:0]) begin
                errors++;
                $display("FAIL random_first_slice[%0d]: adder_a=%h, required %h", i, fa, a[4:0]);
            end
        end
    endtask

    task automatic test_start_during_run;
        int dones = 0;
        logic [OW-1:0] s = '0;
        logic [OW:0] r;
        r = ref_op(20'h0ABCD, 20'h01111, 1'b0, 1'b0);
        @(posedge clk); #1;
        a_in = 20'h0ABCD; b_in = 20'h01111; cin_in = 1'b0; sub_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a_in = 20'h12345; b_in = 20'h54321; cin_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin dones++; s = sum_out; end
            @(posedge clk); #1;
        end
        $display("start_during_run: dones=%0d sum=%h", dones, s);
        checks++;
        if (dones !== 1 || s !== r[OW-1:0]) begin
            errors++;
            $display("FAIL start_during_run: dones=%0d sum=%h, required 1 and %h", dones, s, r[OW-1:0]);
        end
    endtask

    task automatic test_reset_mid_run;
        int dones = 0;
        @(posedge clk); #1;
        a_in = 20'hFFFFF; b_in = 20'h00001; cin_in = 1'b0; sub_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        $display("reset_mid_run: busy=%b done=%b sum=%h cout=%b", busy, done, sum_out, cout_out);
        checks++;
        if ({busy, done, sum_out, cout_out, adder_a, adder_b, adder_cin} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b sum=%h cout=%b a=%h, required all 0",
                     busy, done, sum_out, cout_out, adder_a);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) dones++;
            @(posedge clk); #1;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_no_done: %0d busy/done cycles after abort, required 0", dones);
        end
    endtask

    // Start held high: DONE ignores it, so the next operation is accepted on the edge after leaving DONE.
    task automatic test_back_to_back;
        int first = -1;
        int second = -1;
        int cyc = 0;
        @(posedge clk); #1;
        a_in = 20'h00010; b_in = 20'h00020; cin_in = 1'b0; sub_in = 1'b0; start = 1'b1;
        while (second < 0 && cyc < 3 * TMO) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
        end
        start = 1'b0;
        $display("back_to_back: first done at %0d, second at %0d, sum=%h", first, second, sum_out);
        checks++;
        if (first !== WORDS + 1 || second - first !== WORDS + 2) begin
            errors++;
            $display("FAIL back_to_back: done at %0d and %0d, required %0d and %0d",
                     first, second, WORDS + 1, 2 * WORDS + 3);
        end
        checks++;
        if (sum_out !== 20'h00030 || cout_out !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_result: sum=%h cout=%b, required 00030 0", sum_out, cout_out);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

`ifdef ADDSEQ_SUB_EN
    task automatic test_sub;
        int lat, bc;
        logic [OW-1:0] s, a, b;
        logic c, da;
        logic [4:0] fa;
        logic [OW:0] r;
        do_op(20'h00005, 20'h00007, 1'b0, 1'b1, lat, bc, s, c, da, fa);
        $display("sub 5-7: sum=%h cout=%b", s, c);
        checks++;
        if (s !== 20'hFFFFE || c !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: sum=%h cout=%b, required FFFFE 0", s, c);
        end
        do_op(20'h00007, 20'h00005, 1'b0, 1'b1, lat, bc, s, c, da, fa);
        $display("sub 7-5: sum=%h cout=%b", s, c);
        checks++;
        if (s !== 20'h00002 || c !== 1'b1) begin
            errors++;
            $display("FAIL sub_no_borrow: sum=%h cout=%b, required 00002 1", s, c);
        end
        for (int i = 0; i < 10; i++) begin
            a = OW'($urandom);
            b = OW'($urandom);
            r = ref_op(a, b, 1'b0, 1'b1);
            do_op(a, b, 1'b0, 1'b1, lat, bc, s, c, da, fa);
            $display("sub random %0d: A=%h B=%h -> %h %b", i, a, b, s, c);
            checks++;
            if (s !== r[OW-1:0] || c !== r[OW]) begin
                errors++;
                $display("FAIL sub_random[%0d]: sum=%h cout=%b, required %h %b", i, s, c, r[OW-1:0], r[OW]);
            end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_start_during_run;
        test_reset_mid_run;
        test_back_to_back;
`ifdef ADDSEQ_SUB_EN
        test_sub;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
